key_event_arbiter: RTL and testbench
====================================

// Module: key_event_arbiter
// PURPOSE
//  Collects single-cycle key_flag pulses from KEY_NUM debounce filters and queues them as key codes.
//  Simultaneous presses are serialised by round-robin arbitration into a FIFO_DEPTH-deep event queue.
//  The queue is read by the consumer (display/menu FSM) over a valid/ready handshake.
//  Sits between the per-key debounce filters and any key-driven control logic.
// PARAMETERS
//  KEY_NUM    4  number of key_flag inputs (2..16)
//  CODE_W     2  key code width; 2**CODE_W >= KEY_NUM
//  FIFO_DEPTH 4  event queue depth; power of two, >= 2
//  PTR_W      2  log2(FIFO_DEPTH)
// PORTS
//  sys_clk    in   1        system clock, all logic on rising edge
//  sys_rst_n  in   1        asynchronous active-low reset
//  key_flag   in   KEY_NUM  one-cycle press pulses, bit i = key i
//  evt_ready  in   1        consumer accepts evt_code this cycle
//  evt_valid  out  1        queue non-empty, evt_code valid
//  evt_code   out  CODE_W   index of oldest queued key press
//  fifo_full  out  1        queue holds FIFO_DEPTH entries
//  pend       out  KEY_NUM  pending (sampled, not yet queued) keys
// BEHAVIOUR
//  Reset: pend=0, rr_ptr=0, wr/rd ptr=0, count=0; evt_valid=0, evt_code=0, fifo_full=0.
//  Reset applies at any time, including mid-queue; all queued and pending events are discarded.
//  Stage 1, pending: at each edge, pend[i] <= (pend[i] & ~grant[i]) | key_flag[i].
//   - If key_flag[i] and grant[i] occur in the same cycle, pend[i] stays 1 (second event kept).
//   - If key_flag[i] arrives while pend[i]=1 and grant[i]=0, the press merges (dropped).
//  Stage 2, arbitration (combinational on registered pend):
//   - Grant only when count < FIFO_DEPTH; no write-through-on-pop when full.
//   - Search pend from index rr_ptr upward, wrapping at KEY_NUM-1 -> 0; first set bit wins.
//   - At most one grant per cycle.
//   - On grant g: write g into mem[wr_ptr], wr_ptr++ (wraps mod FIFO_DEPTH), rr_ptr <= (g+1) mod KEY_NUM.
//   - No grant: rr_ptr holds.
//  Queue: show-ahead FIFO.
//   - evt_valid = (count != 0); evt_code = mem[rd_ptr] when valid, else 0.
//   - Pop on evt_valid & evt_ready: rd_ptr++ (wraps).
//   - Push and pop in the same cycle: count unchanged.
//   - evt_ready while empty is ignored.
//   - fifo_full = (count == FIFO_DEPTH); count width PTR_W+1.
//  Latency: key_flag high in cycle N -> pend set after edge N -> evt_valid high in cycle N+2
//   (queue empty, not full, key wins arbitration).
//  Full: pend bits are held (never lost) until space frees; the grant occurs the cycle after the pop.
// CONFIGURATION
//  KEY_DROP_CNT_EN defined:
//   - Adds output drop_cnt [7:0], reset 0.
//   - Increments once per cycle in which >=1 press merged per Stage 1 rule; saturates at 255.
//  Not defined: port and counter absent; merged presses are silently dropped.
// TESTING
//  1 key_flag=4'b0100 one cycle, evt_ready=1 -> evt_valid 1 cycle at N+2, evt_code=2; then empty.
//  2 key_flag=4'b1011 same cycle, rr_ptr=0, ready=1 -> codes 0,1,3 on consecutive cycles; rr_ptr ends 0.
//  3 ready=0, four presses keys 0..3, then key0 again:
//    - fifo_full=1 and pend=4'b0001.
//    - One pop -> code 0 written next cycle, full again.
//  4 KEY_DROP_CNT_EN, ready=0, FIFO full, key1 pulsed 3x:
//    - drop_cnt=2 and one key1 event queued.
//    - 300 merges -> drop_cnt=255.
//  5 key0 flagged every cycle plus key1 pending, ready=1 -> queued codes alternate 0,1,0,...
//  6 assert sys_rst_n=0 with 3 queued and 2 pending -> all outputs 0; no stale events after release.

Source files
------------

// File: rtl/key_event_arbiter.sv
// -----------------------------------------------------------------------------
// key_event_arbiter
//
// Collects one-cycle key_flag pulses from the per-key debounce filters, keeps
// them in a pending register, serialises simultaneous presses with a
// round-robin arbiter and stores the winning key codes in a small show-ahead
// FIFO. The consumer reads the FIFO over a valid/ready handshake.
//
// Ports
//   sys_clk    in   1        system clock, rising edge
//   sys_rst_n  in   1        asynchronous active-low reset
//   key_flag   in   KEY_NUM  one-cycle press pulses, bit i = key i
//   evt_ready  in   1        consumer accepts evt_code this cycle
//   evt_valid  out  1        queue non-empty, evt_code valid
//   evt_code   out  CODE_W   index of the oldest queued key press
//   fifo_full  out  1        queue holds FIFO_DEPTH entries
//   pend       out  KEY_NUM  keys sampled but not yet queued
//   drop_cnt   out  8        merged-press counter (only with KEY_DROP_CNT_EN)
//
// Optional feature macro: KEY_DROP_CNT_EN
//   Defined     -> drop_cnt port present; counts cycles in which at least one
//                  press merged into an already pending bit, saturating at 255.
//   Not defined -> no drop_cnt port; merged presses are silently dropped.
//
// Handshake: an event transfers on every rising edge where evt_valid and
// evt_ready are both high. evt_valid depends only on registered state, never
// on evt_ready; evt_ready while the queue is empty has no effect. evt_code is
// forced to 0 whenever evt_valid is low.
// -----------------------------------------------------------------------------
module key_event_arbiter #(
   parameter int KEY_NUM    = 4,
   parameter int CODE_W     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_W      = 2
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic [KEY_NUM-1:0]  key_flag,
   input  logic                evt_ready,
   output logic                evt_valid,
   output logic [CODE_W-1:0]   evt_code,
   output logic                fifo_full,
   output logic [KEY_NUM-1:0]  pend
`ifdef KEY_DROP_CNT_EN
   ,
   output logic [7:0]          drop_cnt
`endif
);

   localparam logic [PTR_W:0]    DEPTH_C    = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [CODE_W:0]   KEY_NUM_C  = (CODE_W+1)'(KEY_NUM);
   localparam logic [CODE_W-1:0] LAST_KEY_C = CODE_W'(KEY_NUM-1);

   logic [CODE_W-1:0]  rr_ptr;
   logic [CODE_W-1:0]  grant_idx;
   logic               grant_vld;
   logic [KEY_NUM-1:0] grant;
   logic [CODE_W:0]    idx_sum;

   logic [CODE_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W:0]     count;
   logic               push;
   logic               pop;

   // Round-robin search over the registered pending bits, starting at rr_ptr
   // and wrapping at KEY_NUM-1. The first set bit wins. No grant is issued
   // while the queue is full, even if a pop happens in the same cycle, so a
   // held key is granted the cycle after space frees.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      grant     = '0;
      idx_sum   = '0;
      if (count < DEPTH_C) begin
         for (int k = 0; k < KEY_NUM; k++) begin
            idx_sum = {1'b0, rr_ptr} + (CODE_W+1)'(k);
            if (idx_sum >= KEY_NUM_C) begin
               idx_sum = idx_sum - KEY_NUM_C;
            end
            if (!grant_vld && pend[idx_sum[CODE_W-1:0]]) begin
               grant_vld = 1'b1;
               grant_idx = idx_sum[CODE_W-1:0];
            end
         end
      end
      if (grant_vld) begin
         grant[grant_idx] = 1'b1;
      end
   end

   assign push = grant_vld;
   assign pop  = evt_valid & evt_ready;

   // A new pulse on a key granted this cycle re-arms its pending bit, so the
   // second press is kept; a pulse on a pending, ungranted key merges.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pend <= '0;
      end else begin
         pend <= (pend & ~grant) | key_flag;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rr_ptr <= '0;
      end else if (grant_vld) begin
         rr_ptr <= (grant_idx == LAST_KEY_C) ? '0 : grant_idx + 1'b1;
      end
   end

   // Event queue storage and pointers. FIFO_DEPTH is a power of two, so the
   // pointers wrap naturally.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= grant_idx;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign evt_valid = (count != '0);
   assign evt_code  = evt_valid ? mem[rd_ptr] : '0;
   assign fifo_full = (count == DEPTH_C);

`ifdef KEY_DROP_CNT_EN
   logic merged;

   assign merged = |(key_flag & pend & ~grant);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         drop_cnt <= '0;
      end else if (merged && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_key_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_key_event_arbiter
//
// Directed bench for key_event_arbiter (KEY_NUM=4, CODE_W=2, FIFO_DEPTH=4).
// Each step drives inputs just after a rising edge, compares outputs on the
// falling edge (state left by the previous edge) and then advances one clock.
// -----------------------------------------------------------------------------
module tb_key_event_arbiter;

   logic       sys_clk;
   logic       sys_rst_n;
   logic [3:0] key_flag;
   logic       evt_ready;
   logic       evt_valid;
   logic [1:0] evt_code;
   logic       fifo_full;
   logic [3:0] pend;
`ifdef KEY_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int n_vec;
   int n_err;

   key_event_arbiter #(
      .KEY_NUM    (4),
      .CODE_W     (2),
      .FIFO_DEPTH (4),
      .PTR_W      (2)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_flag  (key_flag),
      .evt_ready (evt_ready),
      .evt_valid (evt_valid),
      .evt_code  (evt_code),
      .fifo_full (fifo_full),
      .pend      (pend)
`ifdef KEY_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   // clock / reset
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic       rst;
      logic [3:0] kf;
      logic       rdy;
      logic       ev;
      logic [1:0] ec;
      logic       ef;
      logic [3:0] ep;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      key_flag  = '0;
      evt_ready = 1'b0;
      @(posedge sys_clk);
      @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".valid"}, 32'(evt_valid), 32'd0);
      check({tag, ".code"},  32'(evt_code),  32'd0);
      check({tag, ".full"},  32'(fifo_full), 32'd0);
      check({tag, ".pend"},  32'(pend),      32'd0);
`ifdef KEY_DROP_CNT_EN
      check({tag, ".drop"},  32'(drop_cnt),  32'd0);
`endif
   endtask

   // driver: one cycle of stimulus plus comparison of the cycle's outputs
   task automatic step(input string tag, input logic [3:0] kf, input logic rdy,
                       input logic ev, input logic [1:0] ec, input logic ef,
                       input logic [3:0] ep);
      key_flag  = kf;
      evt_ready = rdy;
      @(negedge sys_clk);
      check({tag, ".valid"}, 32'(evt_valid), 32'(ev));
      check({tag, ".code"},  32'(evt_code),  32'(ec));
      check({tag, ".full"},  32'(fifo_full), 32'(ef));
      check({tag, ".pend"},  32'(pend),      32'(ep));
      @(posedge sys_clk);
      #1;
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      sys_rst_n = 1'b0;
      key_flag  = '0;
      evt_ready = 1'b0;

      #2;
      check_all_zero("reset_state");
      do_reset();
      check_all_zero("after_release");

      // --- table: single press, 3-key burst + rr restart, alternating keys ---
      //             rst   kf       rdy   ev    ec     ef    ep
      tbl.push_back('{1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0100});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0000});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});

      tbl.push_back('{1'b1, 4'b1011, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1011});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b1010});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 4'b1000});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4'b0000});
      // rr pointer is back at 0: keys 0 and 3 together must give 0 first
      tbl.push_back('{1'b0, 4'b1001, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1001});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b1000});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4'b0000});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});

      tbl.push_back('{1'b1, 4'b0011, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
      tbl.push_back('{1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0011});
      tbl.push_back('{1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0011});
      tbl.push_back('{1'b0, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0001});
      tbl.push_back('{1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0011});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0001});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});

      foreach (tbl[i]) begin
         if (tbl[i].rst) begin
            do_reset();
         end
         step($sformatf("tbl%0d", i), tbl[i].kf, tbl[i].rdy, tbl[i].ev,
              tbl[i].ec, tbl[i].ef, tbl[i].ep);
      end

      // --- full queue holds the pending key until a pop frees space ---
      do_reset();
      step("full_a", 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
      step("full_b", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b1111);
      step("full_c", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b1110);
      step("full_d", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b1100);
      step("full_e", 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, 4'b1000);
      step("full_f", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001);
      step("full_g", 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0001);
      step("full_h", 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0000);
      step("full_i", 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0000);
      step("full_j", 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4'b0000);
      step("full_k", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000);
      step("full_l", 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000);

`ifdef KEY_DROP_CNT_EN
      // --- merged presses while full, then saturation ---
      do_reset();
      step("drop_a", 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
      step("drop_b", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b1111);
      step("drop_c", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b1110);
      step("drop_d", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b1100);
      step("drop_e", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b1000);
      step("drop_f", 4'b0010, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000);
      step("drop_g", 4'b0010, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0010);
      step("drop_h", 4'b0010, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0010);
      check("drop_cnt_2", 32'(drop_cnt), 32'd2);
      step("drop_i", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0010);
      step("drop_j", 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0010);
      step("drop_k", 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0000);
      step("drop_l", 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0000);
      step("drop_m", 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4'b0000);
      step("drop_n", 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0000);
      step("drop_o", 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000);
      check("drop_cnt_still_2", 32'(drop_cnt), 32'd2);

      // key1 held high: 1 cycle to set pend, 4 grants fill the queue,
      // every later cycle is a merge
      for (int i = 0; i < 105; i++) begin
         key_flag  = 4'b0010;
         evt_ready = 1'b0;
         @(posedge sys_clk);
         #1;
      end
      key_flag = 4'b0000;
      @(negedge sys_clk);
      check("drop_cnt_102", 32'(drop_cnt), 32'd102);
      @(posedge sys_clk);
      #1;
      for (int i = 0; i < 250; i++) begin
         key_flag = 4'b0010;
         @(posedge sys_clk);
         #1;
      end
      key_flag = 4'b0000;
      @(negedge sys_clk);
      check("drop_cnt_sat", 32'(drop_cnt), 32'd255);
      check("drop_sat_pend", 32'(pend), 32'h2);
      check("drop_sat_full", 32'(fifo_full), 32'd1);
      @(posedge sys_clk);
      #1;
`endif

      // --- asynchronous reset with 3 queued and 2 pending ---
      do_reset();
      step("rst_a", 4'b0111, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
      step("rst_b", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0111);
      step("rst_c", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0110);
      step("rst_d", 4'b1001, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0100);
      key_flag = 4'b0000;
      check("rst_pre.valid", 32'(evt_valid), 32'd1);
      check("rst_pre.pend",  32'(pend),      32'h9);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check_all_zero("rst_async");
      @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;
      step("rst_e", 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000);
      step("rst_f", 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000);
      step("rst_g", 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
